// File: rtl/nios2_mul_cell_arbiter_if.sv
// Bundle of requester, response and multiplier-cell signals around nios2_mul_cell_arbiter.
// The slave modport is the arbiter's view; the master modport is its environment.
interface nios2_mul_cell_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_src1;
    logic [32*NUM_REQ-1:0] req_src2;
    logic [NUM_REQ-1:0]    req_src1_signed;
    logic [NUM_REQ-1:0]    req_src2_signed;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [63:0]           rsp_result;

    logic [31:0]           mul_src1;
    logic [31:0]           mul_src2;
    logic                  mul_src1_signed;
    logic                  mul_src2_signed;
    logic                  mul_en_in;
    logic                  mul_en_out;
    logic [63:0]           mul_result;

    modport slave (
        input  req_valid, req_src1, req_src2, req_src1_signed, req_src2_signed,
        input  rsp_ready, mul_result,
        output req_ready, rsp_valid, rsp_id, rsp_result,
        output mul_src1, mul_src2, mul_src1_signed, mul_src2_signed, mul_en_in, mul_en_out
    );

    modport master (
        output req_valid, req_src1, req_src2, req_src1_signed, req_src2_signed,
        output rsp_ready, mul_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result,
        input  mul_src1, mul_src2, mul_src1_signed, mul_src2_signed, mul_en_in, mul_en_out
    );
endinterface

// File: rtl/nios2_mul_cell_arbiter.sv
// Round-robin arbiter sharing one two-stage pipelined 32x32->64 multiplier cell.
// Optional stall counter enabled by defining NIOS2_MUL_ARB_STALL_CNT_EN.
module nios2_mul_cell_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef NIOS2_MUL_ARB_STALL_CNT_EN
    input  logic        stall_cnt_clr,
    output logic [31:0] stall_cnt,
`endif
    nios2_mul_cell_arbiter_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int IDX_W = ID_W + 1;

    logic                v1, v2;
    logic [ID_W-1:0]     id1, id2;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_nxt;
    logic                adv;
    logic [NUM_REQ-1:0]  grant;
    logic                any_grant;
    logic [ID_W-1:0]     gnt_idx;
    logic [SEL_W-1:0]    sel;
    logic [IDX_W-1:0]    idx;

    logic [31:0]         src1_arr [NUM_REQ];
    logic [31:0]         src2_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign src1_arr[g] = bus.req_src1[32*g +: 32];
        assign src2_arr[g] = bus.req_src2[32*g +: 32];
    end

    // The cell's output register is the only place a finished product can wait,
    // so the whole pipe freezes while it holds an unaccepted result.
    assign adv = ~v2 | bus.rsp_ready;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + IDX_W'(k);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end
            if (!any_grant && bus.req_valid[idx[SEL_W-1:0]]) begin
                any_grant                = 1'b1;
                gnt_idx                  = idx[ID_W-1:0];
                grant[idx[SEL_W-1:0]]    = 1'b1;
            end
        end
    end

    assign sel    = gnt_idx[SEL_W-1:0];
    assign rr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            id1    <= '0;
            id2    <= '0;
            rr_ptr <= '0;
        end else if (adv) begin
            v2  <= v1;
            id2 <= id1;
            v1  <= any_grant;
            id1 <= gnt_idx;
            if (any_grant) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

    // Accepts are masked while reset is held so no requester sees a phantom handshake.
    assign bus.req_ready       = (adv && reset_n) ? grant : '0;
    assign bus.mul_src1        = any_grant ? src1_arr[sel] : '0;
    assign bus.mul_src2        = any_grant ? src2_arr[sel] : '0;
    assign bus.mul_src1_signed = any_grant & bus.req_src1_signed[sel];
    assign bus.mul_src2_signed = any_grant & bus.req_src2_signed[sel];
    assign bus.mul_en_in       = adv;
    assign bus.mul_en_out      = adv;

    assign bus.rsp_valid  = v2;
    assign bus.rsp_id     = id2;
    assign bus.rsp_result = bus.mul_result;

`ifdef NIOS2_MUL_ARB_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (v2 && !bus.rsp_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nios2_mul_cell_arbiter.sv
// Self-checking bench for nios2_mul_cell_arbiter: directed scenarios then random traffic,
// compared against a scoreboard model of grant order, latency and products.
module tb_nios2_mul_cell_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 2;

    logic clk;
    logic reset_n;
`ifdef NIOS2_MUL_ARB_STALL_CNT_EN
    logic        stall_cnt_clr;
    logic [31:0] stall_cnt;
`endif

    nios2_mul_cell_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    nios2_mul_cell_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
`ifdef NIOS2_MUL_ARB_STALL_CNT_EN
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt),
`endif
        .bus           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b, logic sa, logic sb);
        longint ea, eb;
        ea = sa ? longint'($signed(a)) : longint'({32'd0, a});
        eb = sb ? longint'($signed(b)) : longint'({32'd0, b});
        return 64'(ea * eb);
    endfunction

    // Multiplier cell: input register on ena0, product register on ena1, async clear.
    logic [31:0] c_a, c_b;
    logic        c_sa, c_sb;
    logic [63:0] c_res;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_a <= '0; c_b <= '0; c_sa <= 1'b0; c_sb <= 1'b0; c_res <= '0;
        end else begin
            if (bus.mul_en_in) begin
                c_a <= bus.mul_src1; c_b <= bus.mul_src2;
                c_sa <= bus.mul_src1_signed; c_sb <= bus.mul_src2_signed;
            end
            if (bus.mul_en_out) c_res <= ref_prod(c_a, c_b, c_sa, c_sb);
        end
    end
    assign bus.mul_result = c_res;

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          m_ptr;
    int          adv_cnt;
    logic [31:0] m_stall;

    logic [31:0] r_a [NUM_REQ];
    logic [31:0] r_b [NUM_REQ];
    logic        r_sa [NUM_REQ];
    logic        r_sb [NUM_REQ];
    logic        r_valid [NUM_REQ];
    logic        rsp_rdy;
    logic        clr;

    int n_checks = 0;
    int n_pass   = 0;
    int last_acc;
    bit last_rsp;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic sa, logic sb);
        r_valid[i] = 1'b1; r_a[i] = a; r_b[i] = b; r_sa[i] = sa; r_sb[i] = sb;
    endtask

    task automatic set_rand_op(int i);
        set_op(i, rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]            = r_valid[i];
            bus.req_src1[32*i +: 32]    = r_a[i];
            bus.req_src2[32*i +: 32]    = r_b[i];
            bus.req_src1_signed[i]      = r_sa[i];
            bus.req_src2_signed[i]      = r_sb[i];
        end
        bus.rsp_ready = rsp_rdy;
`ifdef NIOS2_MUL_ARB_STALL_CNT_EN
        stall_cnt_clr = clr;
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ptr   = 0;
        adv_cnt = 0;
        m_stall = '0;
    endtask

    // One clock: check outputs against the model just before the edge, then advance the model.
    task automatic tick();
        bit              ev, eadv;
        int              gi;
        logic [NUM_REQ-1:0] er;
        drive();
        #1;
        ev = (exp_q.size() > 0) && (exp_q[0].due <= adv_cnt);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
        if (ev) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(exp_q[0].id));
            chk("rsp_result", bus.rsp_result, exp_q[0].prod);
        end
        eadv = !ev || rsp_rdy;
        chk("mul_en_in", 64'(bus.mul_en_in), 64'(eadv));
        chk("mul_en_out", 64'(bus.mul_en_out), 64'(eadv));
        gi = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (m_ptr + k) % NUM_REQ;
            if (gi < 0 && r_valid[j]) gi = j;
        end
        er = (eadv && gi >= 0) ? (NUM_REQ'(1) << gi) : '0;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        if (gi >= 0) begin
            chk("mul_src1", 64'(bus.mul_src1), 64'(r_a[gi]));
            chk("mul_src2", 64'(bus.mul_src2), 64'(r_b[gi]));
            chk("mul_signs", 64'({bus.mul_src1_signed, bus.mul_src2_signed}), 64'({r_sa[gi], r_sb[gi]}));
        end else begin
            chk("mul_src_idle", 64'({bus.mul_src1, bus.mul_src2}), 64'd0);
        end
`ifdef NIOS2_MUL_ARB_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        last_acc = -1;
        for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_ready[i] && bus.req_valid[i]) last_acc = i;
        last_rsp = bus.rsp_valid && bus.rsp_ready;

        if (ev && rsp_rdy) void'(exp_q.pop_front());
        if (eadv) begin
            if (gi >= 0) begin
                exp_q.push_back('{id: gi, prod: ref_prod(r_a[gi], r_b[gi], r_sa[gi], r_sb[gi]), due: adv_cnt + 2});
                m_ptr = (gi + 1) % NUM_REQ;
            end
            adv_cnt++;
        end
        if (clr) m_stall = '0;
        else if (ev && !rsp_rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int first;
        int n_rsp;
        int guard;
        reset_n = 1'b0;
        rsp_rdy = 1'b0;
        clr     = 1'b0;
        last_acc = -1;
        last_rsp = 1'b0;
        set_op(0, 32'h1234_5678, 32'h9, 1'b1, 1'b0);
        set_op(1, 32'hCAFE_0001, 32'h3, 1'b0, 1'b1);
        drive();
        #2;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_en_in", 64'(bus.mul_en_in), 64'd1);
        chk("rst_en_out", 64'(bus.mul_en_out), 64'd1);
        chk("rst_mul_src1", 64'(bus.mul_src1), 64'h1234_5678);
        chk("rst_mul_signs", 64'({bus.mul_src1_signed, bus.mul_src2_signed}), 64'b10);
`ifdef NIOS2_MUL_ARB_STALL_CNT_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        for (int i = 0; i < NUM_REQ; i++) r_valid[i] = 1'b0;
        drive();
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Single unsigned op
        rsp_rdy = 1'b1;
        set_op(0, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
        tick();
        chk("t1_accept", 64'(last_acc), 64'(0));
        r_valid[0] = 1'b0;
        tick();
        chk("t1_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t1_result", bus.rsp_result, 64'h0000_0001_FFFF_FFFE);
        chk("t1_id", 64'(bus.rsp_id), 64'd0);

        // Signed op from requester 1
        set_op(1, 32'hFFFF_FFFD, 32'h7, 1'b1, 1'b1);
        tick();
        r_valid[1] = 1'b0;
        tick();
        chk("t2_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t2_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("t2_id", 64'(bus.rsp_id), 64'd1);

        // Round robin with both requesters continuously valid
        set_rand_op(0);
        set_rand_op(1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", 64'(last_acc), 64'(k % 2));
            if (k >= 1) chk("rr_rsp_id", 64'(bus.rsp_id), 64'((k - 1) % 2));
            if (last_acc >= 0) set_rand_op(last_acc);
        end
        for (int i = 0; i < NUM_REQ; i++) r_valid[i] = 1'b0;
        repeat (3) tick();

        // Backpressure: three ops, consumer stalled for five cycles
        rsp_rdy = 1'b0;
        set_op(0, 32'h3, 32'h5, 1'b0, 1'b0);
        set_op(1, 32'h8000_0000, 32'h2, 1'b1, 1'b1);
        tick();
        first = last_acc;
        chk("bp_first", 64'(first), 64'(0));
        set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tick();
        chk("bp_second", 64'(last_acc), 64'(1));
        r_valid[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_hold_result", bus.rsp_result, 64'd15);
            chk("bp_hold_id", 64'(bus.rsp_id), 64'd0);
        end
        rsp_rdy = 1'b1;
        n_rsp = 0;
        guard = 0;
        while (n_rsp < 3 && guard < 10) begin
            tick();
            if (last_acc == 0) r_valid[0] = 1'b0;
            if (last_rsp) n_rsp++;
            guard++;
        end
        chk("bp_count", 64'(n_rsp), 64'(3));
        chk("bp_no_dup", 64'(bus.rsp_valid), 64'd0);

`ifdef NIOS2_MUL_ARB_STALL_CNT_EN
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_op(0, 32'h11, 32'h22, 1'b0, 1'b0);
        rsp_rdy = 1'b0;
        tick();
        r_valid[0] = 1'b0;
        tick();
        repeat (4) tick();
        chk("stall_four", 64'(stall_cnt), 64'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("stall_clr", 64'(stall_cnt), 64'd0);
        rsp_rdy = 1'b1;
        repeat (3) tick();
`endif

        // Reset while both pipe stages are occupied
        rsp_rdy = 1'b0;
        set_op(1, rand_word(), rand_word(), 1'b0, 1'b1);
        tick();
        r_valid[1] = 1'b0;
        set_op(0, rand_word(), rand_word(), 1'b1, 1'b0);
        tick();
        chk("rst_mid_pre", 64'(bus.rsp_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_mid_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_mid_ready", 64'(bus.req_ready), 64'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) r_valid[i] = 1'b0;
        rsp_rdy = 1'b1;
        tick();
        tick();
        set_op(0, 32'hFFFF_FFF0, 32'h10, 1'b1, 1'b0);
        set_op(1, 32'h7, 32'h9, 1'b0, 1'b0);
        tick();
        chk("rst_rr_ptr", 64'(last_acc), 64'(0));
        r_valid[0] = 1'b0;
        tick();
        r_valid[1] = 1'b0;
        chk("rst_first_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FF00);
        repeat (3) tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_acc == i) r_valid[i] = 1'b0;
                if (!r_valid[i] && $urandom_range(0, 2) != 0) set_rand_op(i);
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
            clr     = ($urandom_range(0, 15) == 0);
            tick();
        end
        for (int i = 0; i < NUM_REQ; i++) r_valid[i] = 1'b0;
        rsp_rdy = 1'b1;
        clr     = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
